// File: rtl/spi_adc_slave_pkg.sv
// Shared definitions for the SPI ADC emulator.
//  - Default geometry of the serial frame and the derived FRAME_LEN / CNT_W.
//  - Frame FSM state type and state constants.
//  - Default sdata level while deselected.
// No ports (package).
package spi_adc_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int LEAD_ZEROS_DEF  = 3;
  localparam int TRAIL_ZEROS_DEF = 4;
  localparam int SYNC_STAGES_DEF = 2;

  // Bits on the wire per frame: leading zeros, sample (MSB first), trailing zeros.
  localparam int FRAME_LEN = LEAD_ZEROS_DEF + DATA_W_DEF + TRAIL_ZEROS_DEF;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  localparam logic IDLE_LEVEL_DEF = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_TAIL  = 2'd2;

endpackage

// File: rtl/spi_adc_slave_if.sv
// Bus bundle between an SPI master / sample source and spi_adc_slave.
//  sclk, cs_n    : SPI clock and active-low select (master -> slave)
//  sdata         : serial data (slave -> master)
//  sample_data,
//  sample_valid  : parallel sample offered by the source (master side)
//  sample_ready  : slave can take a sample (slave -> source)
// Modports: master (drives SPI pins and samples), slave (the ADC emulator).
interface spi_adc_slave_if
  import spi_adc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              sclk;
  logic              cs_n;
  logic              sdata;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sclk, cs_n, sample_data, sample_valid,
    input  sdata, sample_ready
  );

  modport slave (
    input  sclk, cs_n, sample_data, sample_valid,
    output sdata, sample_ready
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, followed by one edge-detect
// flop producing single-clk rise/fall pulses.
// Ports:
//  clk, rst : system clock, synchronous active-high reset
//  din      : asynchronous input pin
//  rise     : 1-clk pulse on a synchronized 0->1 transition
//  fall     : 1-clk pulse on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;
  // Tracks how far real pin samples have travelled down the chain since reset.
  // Edges are suppressed until the edge-detect flop holds a real sample, so a
  // pin that is already low at reset release is not mistaken for a fall.
  logic [STAGES:0]   vld_reg;

  always_ff @(posedge clk) begin
    if (rst) sync_reg[0] <= 1'b0;
    else     sync_reg[0] <= din;
  end

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_sync
    always_ff @(posedge clk) begin
      if (rst) sync_reg[gi] <= 1'b0;
      else     sync_reg[gi] <= sync_reg[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= 1'b0;
      vld_reg  <= '0;
    end else begin
      prev_reg <= sync_reg[STAGES-1];
      vld_reg  <= {vld_reg[STAGES-1:0], 1'b1};
    end
  end

  assign rise = vld_reg[STAGES] &  sync_reg[STAGES-1] & ~prev_reg;
  assign fall = vld_reg[STAGES] & ~sync_reg[STAGES-1] &  prev_reg;

endmodule

// File: rtl/spi_adc_slave.sv
// SPI responder emulating an 8-bit serial ADC. A one-deep holding register
// takes parallel samples; each cs_n-low frame shifts out
// {LEAD_ZEROS zeros, sample MSB first, TRAIL_ZEROS zeros} on sclk falling edges.
// sclk and cs_n are oversampled in the clk domain (pin-to-sdata SYNC_STAGES+1 clk).
// Ports:
//  clk, rst    : system clock, synchronous active-high reset
//  bus (slave) : sclk, cs_n, sdata, sample_data/valid/ready
//  busy        : frame in progress
//  frame_done  : 1-clk pulse, full frame sent and cs_n returned high
//  underrun    : 1-clk pulse, frame started with no sample available
//  abort       : 1-clk pulse, cs_n rose before the frame completed
//  sdata_oe    : (only with SPI_ADC_SLAVE_OE_EN) output enable, equals busy;
//                sdata is then forced 0 while not enabled.
module spi_adc_slave
  import spi_adc_pkg::*;
#(
  parameter int   DATA_W      = DATA_W_DEF,
  parameter int   LEAD_ZEROS  = LEAD_ZEROS_DEF,
  parameter int   TRAIL_ZEROS = TRAIL_ZEROS_DEF,
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic IDLE_LEVEL  = IDLE_LEVEL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_adc_slave_if.slave        bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun,
  output logic                  abort
`ifdef SPI_ADC_SLAVE_OE_EN
  ,
  output logic                  sdata_oe
`endif
);

  localparam int FRM_LEN  = LEAD_ZEROS + DATA_W + TRAIL_ZEROS;
  localparam int CNT_BITS = $clog2(FRM_LEN + 1);

  logic sclk_fall, sclk_rise_unused;
  logic cs_fall, cs_rise;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.sclk),
    .rise (sclk_rise_unused),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  state_t              state_reg;
  logic [FRM_LEN-1:0]  shift_reg;
  logic [CNT_BITS-1:0] cnt_reg;
  logic [DATA_W-1:0]   hold_reg;
  logic                full_reg;
  logic                sdata_reg;
  logic                frame_done_reg, underrun_reg, abort_reg;

  logic accept, load;
  assign accept = bus.sample_valid && !full_reg;
  assign load   = (state_reg == ST_IDLE) && cs_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= '0;
      cnt_reg        <= '0;
      hold_reg       <= '0;
      full_reg       <= 1'b0;
      sdata_reg      <= IDLE_LEVEL;
      frame_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
      abort_reg      <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
      abort_reg      <= 1'b0;

      // A write that coincides with a frame load is routed straight into the
      // shift register by the load branch below instead.
      if (accept && !load) begin
        hold_reg <= bus.sample_data;
        full_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          sdata_reg <= IDLE_LEVEL;
          // Any sclk edge seen with the cs_n fall is absorbed by the load.
          if (cs_fall) begin
            if (full_reg) begin
              shift_reg <= {{LEAD_ZEROS{1'b0}}, hold_reg, {TRAIL_ZEROS{1'b0}}};
              full_reg  <= 1'b0;
            end else if (bus.sample_valid) begin
              shift_reg <= {{LEAD_ZEROS{1'b0}}, bus.sample_data, {TRAIL_ZEROS{1'b0}}};
            end else begin
              shift_reg    <= '0;
              underrun_reg <= 1'b1;
            end
            cnt_reg   <= '0;
            state_reg <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (cs_rise) begin
            abort_reg <= 1'b1;
            sdata_reg <= IDLE_LEVEL;
            state_reg <= ST_IDLE;
          end else if (sclk_fall) begin
            sdata_reg <= shift_reg[FRM_LEN-1];
            shift_reg <= {shift_reg[FRM_LEN-2:0], 1'b0};
            cnt_reg   <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_BITS'(FRM_LEN - 1)) state_reg <= ST_TAIL;
          end
        end

        ST_TAIL: begin
          sdata_reg <= 1'b0;
          if (cs_rise) begin
            frame_done_reg <= 1'b1;
            sdata_reg      <= IDLE_LEVEL;
            state_reg      <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy             = (state_reg != ST_IDLE);
  assign frame_done       = frame_done_reg;
  assign underrun         = underrun_reg;
  assign abort            = abort_reg;
  assign bus.sample_ready = !full_reg;

`ifdef SPI_ADC_SLAVE_OE_EN
  assign sdata_oe  = busy;
  assign bus.sdata = busy ? sdata_reg : 1'b0;
`else
  assign bus.sdata = sdata_reg;
`endif

endmodule

// File: tb/tb_spi_adc_slave.sv
module tb_spi_adc_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, frame_done, underrun, abort;
`ifdef SPI_ADC_SLAVE_OE_EN
  logic sdata_oe;
  localparam logic DESEL_LVL = 1'b0;
`else
  localparam logic DESEL_LVL = 1'b1;
`endif
  localparam logic SEL_IDLE_LVL = 1'b1;

  always #5 clk = ~clk;

  spi_adc_slave_if #(.DATA_W(8)) bus ();

  spi_adc_slave dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun),
    .abort      (abort)
`ifdef SPI_ADC_SLAVE_OE_EN
    ,
    .sdata_oe   (sdata_oe)
`endif
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model of the one-deep holding register.
  bit         m_full = 0;
  logic [7:0] m_hold = '0;

  typedef struct {
    bit          is_abort;
    logic [31:0] bits;
    bit          ur;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] cap_word = '0;

  // Monitor: pops an expectation whenever the DUT reports the end of a frame.
  int ur_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) ur_cnt = 0;
      else begin
        if (underrun) ur_cnt++;
        if (frame_done || abort) begin
          check("end_pulse_with_cs_high", 32'(bus.cs_n), 32'd1);
          if (exp_q.size() == 0) check("unexpected_end_pulse", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("frame_done", 32'(frame_done), 32'(!e.is_abort));
            check("abort", 32'(abort), 32'(e.is_abort));
            check("sdata_bits", cap_word, e.bits);
            check("underrun_count", 32'(ur_cnt), 32'(e.ur));
            $display("frame: abort=%0d bits=%0h underrun=%0d", e.is_abort, cap_word, e.ur);
            ur_cnt = 0;
          end
        end
      end
    end
  end

  task automatic do_write(input logic [7:0] v);
    @(negedge clk);
    check("ready_before_write", 32'(bus.sample_ready), 32'(!m_full));
    bus.sample_data  = v;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    $display("write %02h accepted=%0d", v, !m_full);
    if (!m_full) begin
      m_full = 1;
      m_hold = v;
    end
    check("ready_after_write", 32'(bus.sample_ready), 32'(!m_full));
  endtask

  // One frame: n sclk periods (fall then rise), data captured on each rise.
  task automatic run_frame(input int n, input int wr_at, input logic [7:0] wr_v, input int rst_at);
    logic [31:0] cap = '0;
    logic [31:0] f;
    bit          ur;
    bit          killed = 0;
    exp_t        e;
    @(negedge clk);
    bus.cs_n = 1'b0;
    ur = !m_full;
    f  = m_full ? {20'd0, m_hold, 4'd0} : 32'd0;
    m_full = 0;
    repeat (6) @(negedge clk);
    check("sdata_before_first_fall", 32'(bus.sdata), 32'(SEL_IDLE_LVL));
    check("busy_in_frame", 32'(busy), 32'd1);
    check("ready_after_load", 32'(bus.sample_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      bus.sclk = 1'b0;
      repeat (5) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (5) @(negedge clk);
      cap = {cap[30:0], bus.sdata};
      if (i == wr_at) do_write(wr_v);
      if (i == rst_at && !killed) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_sdata", 32'(bus.sdata), 32'(DESEL_LVL));
        check("rst_ready", 32'(bus.sample_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        m_full = 0;
        killed = 1;
      end
    end
    if (!killed) begin
      e.is_abort = (n < 15);
      e.bits     = (n >= 15) ? (f << (n - 15)) : (f >> (15 - n));
      e.ur       = ur;
      cap_word   = cap;
      exp_q.push_back(e);
    end
    repeat (2) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check("sdata_after_cs_rise", 32'(bus.sdata), 32'(DESEL_LVL));
    check("busy_after_cs_rise", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("scoreboard_consumed", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n, r, wr_at;
    bus.sclk         = 1'b1;
    bus.cs_n         = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_sdata", 32'(bus.sdata), 32'(DESEL_LVL));
    check("reset_ready", 32'(bus.sample_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pulses", {29'd0, frame_done, underrun, abort}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Plain frame with a sample.
    do_write(8'h93);
    run_frame(15, -1, 8'h00, -1);
    // Empty holding register.
    run_frame(15, -1, 8'h00, -1);
    // Mid-frame write feeds the following frame.
    do_write(8'h93);
    run_frame(15, 7, 8'h15, -1);
    run_frame(15, -1, 8'h00, -1);
    // Abort after 6 falls, then a clean frame.
    run_frame(6, -1, 8'h00, -1);
    do_write(8'hB4);
    run_frame(15, -1, 8'h00, -1);
    // Extra sclk falls after the frame.
    do_write(8'hC3);
    run_frame(18, -1, 8'h00, -1);
    // Reset in the middle of shifting, then an empty frame.
    do_write(8'h5A);
    run_frame(15, -1, 8'h00, 7);
    run_frame(15, -1, 8'h00, -1);

    // Randomized frames.
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 3) != 0) do_write(8'($urandom));
      r = $urandom_range(0, 5);
      if (r == 0)      n = $urandom_range(1, 14);
      else if (r == 1) n = $urandom_range(16, 18);
      else             n = 15;
      wr_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      run_frame(n, wr_at, 8'($urandom), -1);
    end

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
